// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall/flush sequencer for the 5-stage pipeline. It handles three cases:
//   - load-use hazards: one-cycle bubble into EX;
//   - taken branches resolved in ID: squash the IF/ID register;
//   - outstanding data-memory accesses: freeze the whole pipeline.
// Priority, from highest: memory wait, load-use, branch.
// All stall/flush controls are combinational from the state register and the
// current inputs, so they take effect on the very next CLK edge.
// A wait counter raises a sticky MemTimeout when an access has been stalled
// for MEM_TIMEOUT cycles in MEM_WAIT.
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating 32-bit
// StallCount / FlushCount outputs.

module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [REG_ADDR_W-1:0] RsD,
  input  logic [REG_ADDR_W-1:0] RtD,
  input  logic [REG_ADDR_W-1:0] RtE,
  input  logic                  MemReadE,
  input  logic                  BranchTakenD,
  input  logic                  MemAccessM,
  input  logic                  MemReadyM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushW,
  output logic                  MemTimeout,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]           StallCount,
  output logic [31:0]           FlushCount,
`endif
  output logic                  Busy
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             timeout_reg;

  logic lu_hit;
  logic mw_hit;
  logic mem_hold;
  logic lu_stall;
  logic br_flush;

  // Raw hazard conditions; register 0 never creates a load-use hazard
  always_comb begin
    lu_hit = MemReadE && (RtE != '0) && ((RtE == RsD) || (RtE == RtD));
    mw_hit = MemAccessM && !MemReadyM;
  end

  // Next-state and hazard arbitration: memory wait beats load-use beats branch
  always_comb begin
    state_next = state_reg;
    mem_hold   = 1'b0;
    lu_stall   = 1'b0;
    br_flush   = 1'b0;
    if ((state_reg == MEM_WAIT) && !MemReadyM) begin
      mem_hold = 1'b1;
    end else if ((state_reg == RUN) && mw_hit) begin
      mem_hold   = 1'b1;
      state_next = MEM_WAIT;
    end else begin
      // RUN without a new wait, or the completing cycle of MEM_WAIT
      state_next = RUN;
      if (lu_hit) begin
        lu_stall = 1'b1;
      end else if (BranchTakenD) begin
        br_flush = 1'b1;
      end
    end
  end

  // Drive the pipeline-register controls; forced low while reset is held
  always_comb begin
    StallF     = RST_N && (mem_hold || lu_stall);
    StallD     = RST_N && (mem_hold || lu_stall);
    FlushD     = RST_N && br_flush;
    FlushE     = RST_N && lu_stall;
    StallE     = RST_N && mem_hold;
    StallM     = RST_N && mem_hold;
    FlushW     = RST_N && mem_hold;
    Busy       = (state_reg == MEM_WAIT);
    MemTimeout = timeout_reg;
  end

  // Wait counter: cleared on entry, counts not-ready cycles, saturates
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if ((state_reg == RUN) && mw_hit) begin
      wait_cnt_next = '0;
    end else if ((state_reg == MEM_WAIT) && !MemReadyM &&
                 (wait_cnt_reg != TIMEOUT_VAL)) begin
      wait_cnt_next = wait_cnt_reg + 1'b1;
    end
  end

  // State, wait counter and sticky timeout flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if ((state_reg == MEM_WAIT) && (wait_cnt_next == TIMEOUT_VAL)) begin
        timeout_reg <= 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  // Saturating event counters for stall cycles and flush cycles
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (StallF && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if ((FlushD || FlushE) && (flush_cnt_reg != 32'hFFFF_FFFF)) begin
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
      end
    end
  end

  assign StallCount = stall_cnt_reg;
  assign FlushCount = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (MEM_TIMEOUT = 4).
// Output vector order: {StallF, StallD, FlushD, FlushE, StallE, StallM, FlushW, Busy}

module tb_pipeline_hazard_ctrl;

  localparam logic [7:0] V_NONE   = 8'h00;
  localparam logic [7:0] V_LU     = 8'hD0;
  localparam logic [7:0] V_LU_BSY = 8'hD1;
  localparam logic [7:0] V_BR     = 8'h20;
  localparam logic [7:0] V_MW_RUN = 8'hCE;
  localparam logic [7:0] V_MW_BSY = 8'hCF;
  localparam logic [7:0] V_READY  = 8'h01;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [4:0] RsD = '0, RtD = '0, RtE = '0;
  logic       MemReadE = 1'b0, BranchTakenD = 1'b0;
  logic       MemAccessM = 1'b0, MemReadyM = 1'b0;
  logic       StallF, StallD, FlushD, FlushE, StallE, StallM, FlushW;
  logic       MemTimeout, Busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCount, FlushCount;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] instr_f = 32'h1234_5678;
  logic [31:0] if_id_reg;
  logic [7:0]  outv;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .RsD(RsD), .RtD(RtD), .RtE(RtE),
    .MemReadE(MemReadE), .BranchTakenD(BranchTakenD),
    .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .StallE(StallE), .StallM(StallM), .FlushW(FlushW),
    .MemTimeout(MemTimeout),
`ifdef HAZARD_PERF_CNT_EN
    .StallCount(StallCount), .FlushCount(FlushCount),
`endif
    .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // Small IF/ID register model steered by the controller's outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)       if_id_reg <= '0;
    else if (FlushD)  if_id_reg <= '0;
    else if (!StallD) if_id_reg <= instr_f;
  end

  assign outv = {StallF, StallD, FlushD, FlushE, StallE, StallM, FlushW, Busy};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_inputs();
    RsD = '0; RtD = '0; RtE = '0;
    MemReadE = 1'b0; BranchTakenD = 1'b0;
    MemAccessM = 1'b0; MemReadyM = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("reset_outputs", {24'd0, outv}, {24'd0, V_NONE});
    chk("reset_timeout", {31'd0, MemTimeout}, 32'd0);
    tick();
    RST_N = 1'b1;
    #1;
    chk("idle", {24'd0, outv}, {24'd0, V_NONE});
    tick();

    // Load-use on Rs
    MemReadE = 1'b1; RtE = 5'd5; RsD = 5'd5; #1;
    chk("lu_rs", {24'd0, outv}, {24'd0, V_LU});
    tick();
    clr_inputs(); #1;
    chk("lu_one_cycle", {24'd0, outv}, {24'd0, V_NONE});

    // Load to r0 never stalls
    MemReadE = 1'b1; RtE = 5'd0; RsD = 5'd0; RtD = 5'd0; #1;
    chk("lu_r0", {24'd0, outv}, {24'd0, V_NONE});

    // Load-use on Rt
    RtE = 5'd7; RtD = 5'd7; RsD = 5'd3; #1;
    chk("lu_rt", {24'd0, outv}, {24'd0, V_LU});
    tick();
    clr_inputs();
    tick();
    chk("ifid_loaded", if_id_reg, 32'h1234_5678);

    // Taken branch squashes IF/ID
    BranchTakenD = 1'b1; instr_f = 32'hDEAD_BEEF; #1;
    chk("branch", {24'd0, outv}, {24'd0, V_BR});
    tick();
    chk("ifid_zero", if_id_reg, 32'h0);
    BranchTakenD = 1'b0; #1;
    chk("branch_one_cycle", {24'd0, outv}, {24'd0, V_NONE});

    // Branch with load-use: bubble wins, no IF/ID flush
    BranchTakenD = 1'b1; MemReadE = 1'b1; RtE = 5'd9; RsD = 5'd9; #1;
    chk("branch_lu", {24'd0, outv}, {24'd0, V_LU});
    tick();
    clr_inputs();

    // Memory wait: 3 not-ready cycles then ready
    MemAccessM = 1'b1; MemReadyM = 1'b0; #1;
    chk("mw_entry", {24'd0, outv}, {24'd0, V_MW_RUN});
    tick();
    BranchTakenD = 1'b1; MemReadE = 1'b1; RtE = 5'd4; RsD = 5'd4; #1;
    chk("mw_wait1_masks", {24'd0, outv}, {24'd0, V_MW_BSY});
    tick();
    chk("mw_wait2", {24'd0, outv}, {24'd0, V_MW_BSY});
    tick();
    MemReadyM = 1'b1; BranchTakenD = 1'b0; MemReadE = 1'b0; #1;
    chk("mw_ready", {24'd0, outv}, {24'd0, V_READY});
    MemReadE = 1'b1; #1;
    chk("mw_ready_lu", {24'd0, outv}, {24'd0, V_LU_BSY});
    tick();
    clr_inputs(); #1;
    chk("mw_back_run", {24'd0, outv}, {24'd0, V_NONE});
    chk("mw_cnt", {29'd0, dut.wait_cnt_reg}, 32'd2);
    chk("mw_no_timeout", {31'd0, MemTimeout}, 32'd0);

    // Ready in the same cycle as the access: no stall, no state change
    MemAccessM = 1'b1; MemReadyM = 1'b1; #1;
    chk("same_cycle_ready", {24'd0, outv}, {24'd0, V_NONE});
    tick();
    chk("same_cycle_no_busy", {24'd0, outv}, {24'd0, V_NONE});
    clr_inputs();

    // Timeout: 10 not-ready cycles, flag rises after 4 cycles in MEM_WAIT
    MemAccessM = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      #1;
      chk($sformatf("to_out_c%0d", i), {24'd0, outv},
          {24'd0, (i == 1) ? V_MW_RUN : V_MW_BSY});
      chk($sformatf("to_flag_c%0d", i), {31'd0, MemTimeout},
          (i >= 6) ? 32'd1 : 32'd0);
      tick();
    end
    chk("to_cnt_sat", {29'd0, dut.wait_cnt_reg}, 32'd4);
    MemReadyM = 1'b1; #1;
    chk("to_ready", {24'd0, outv}, {24'd0, V_READY});
    tick();
    clr_inputs(); #1;
    chk("to_sticky", {31'd0, MemTimeout}, 32'd1);
    chk("to_cnt_hold", {29'd0, dut.wait_cnt_reg}, 32'd4);

    // Asynchronous reset in the middle of MEM_WAIT
    MemAccessM = 1'b1; tick(); tick(); tick();
    #2;
    RST_N = 1'b0; #1;
    chk("arst_outputs", {24'd0, outv}, {24'd0, V_NONE});
    chk("arst_timeout", {31'd0, MemTimeout}, 32'd0);
    chk("arst_cnt", {29'd0, dut.wait_cnt_reg}, 32'd0);
    tick();
    clr_inputs();
    RST_N = 1'b1;
    tick();

`ifdef HAZARD_PERF_CNT_EN
    // 2 load-use stalls and 3 taken branches
    for (int i = 0; i < 2; i++) begin
      MemReadE = 1'b1; RtE = 5'd6; RsD = 5'd6; tick();
      clr_inputs(); tick();
    end
    for (int i = 0; i < 3; i++) begin
      BranchTakenD = 1'b1; tick();
      clr_inputs(); tick();
    end
    chk("perf_stall", StallCount, 32'd2);
    chk("perf_flush", FlushCount, 32'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
